fir_ap_ctrl: RTL

Parametrised block-level control for the FIR engine. It owns the ap_ctrl and data_length configuration registers and drives a multi-state handshake FSM with ap_start, ap_done and ap_idle. It counts AXI-Stream input and output beats, generates sm_tlast, supports restart-after-done, abort and an interrupt. It sits between the AXI-Lite config decoder and the FIR datapath.

---
 rtl/fir_ap_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fir_ap_ctrl.sv
// -----------------------------------------------------------------------------
// fir_ap_ctrl
//
// Block-level control for the FIR engine. Holds the ap_ctrl and data_length
// configuration registers. Runs the IDLE/START/RUN/DONE handshake FSM. Counts
// input and output stream beats, marks the last output beat, and raises a
// level interrupt when a run completes.
//
// Ports
//   axis_clk, axis_rst_n        clock, asynchronous active-low reset
//   cfg_wr_en/addr/data         config write port
//   cfg_rd_en/addr, cfg_rd_data config read port; data valid one cycle later
//   ss_tvalid, ss_tready        input stream handshake, observed
//   ss_accept_en                allows the datapath to raise ss_tready
//   sm_tvalid, sm_tready        output stream handshake, observed
//   sm_tlast                    last output beat marker (combinational)
//   ap_start, ap_done, ap_idle  block-level handshake flags
//   fir_en                      datapath run enable
//   irq                         level interrupt, ap_done & irq_en
//
// ap_ctrl layout: [0] start (W1 request / reads ap_start), [1] done (RO,
// cleared by reading it), [2] idle (RO), [3] abort (WO, reads 0),
// [8] irq_en (RW).
// -----------------------------------------------------------------------------
module fir_ap_ctrl #(
  parameter int unsigned             pADDR_WIDTH = 12,
  parameter int unsigned             pDATA_WIDTH = 32,
  parameter int unsigned             pCNT_WIDTH  = 16,
  parameter logic [pADDR_WIDTH-1:0]  pCTRL_ADDR  = 12'h000,
  parameter logic [pADDR_WIDTH-1:0]  pLEN_ADDR   = 12'h010
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_wr_en,
  input  logic [pADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wr_data,
  input  logic                   cfg_rd_en,
  input  logic [pADDR_WIDTH-1:0] cfg_rd_addr,
  output logic [pDATA_WIDTH-1:0] cfg_rd_data,
  input  logic                   ss_tvalid,
  input  logic                   ss_tready,
  output logic                   ss_accept_en,
  input  logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   fir_en,
  output logic                   irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [pCNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [pCNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic                   irq_en_q, irq_en_d;

  logic                   done_d, start_d, idle_d, fir_en_d, accept_d, irq_d;
  logic [pDATA_WIDTH-1:0] rd_data_d;

  logic [pCNT_WIDTH-1:0]  len_cnt;
  logic [pCNT_WIDTH-1:0]  last_idx;
  logic                   ctrl_wr, len_wr, ctrl_rd;
  logic                   start_req, abort_req;
  logic                   in_beat, out_beat;

  assign len_cnt   = len_q[pCNT_WIDTH-1:0];
  assign last_idx  = len_cnt - CNT_ONE;

  assign ctrl_wr   = cfg_wr_en && (cfg_wr_addr == pCTRL_ADDR);
  assign len_wr    = cfg_wr_en && (cfg_wr_addr == pLEN_ADDR);
  assign ctrl_rd   = cfg_rd_en && (cfg_rd_addr == pCTRL_ADDR);
  assign start_req = ctrl_wr && cfg_wr_data[0];
  assign abort_req = ctrl_wr && cfg_wr_data[3];

  assign in_beat   = ss_tvalid && ss_tready && ss_accept_en;
  assign out_beat  = sm_tvalid && sm_tready;

  // fir_en is only high in RUN, so this marker never fires outside a run even
  // when data_length is 0 (last_idx wraps to all ones).
  assign sm_tlast  = fir_en && (out_cnt_q == last_idx);

  // NOTE: every signal written here gets a default on entry; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    len_d     = len_q;
    irq_en_d  = irq_en_q;
    done_d    = ap_done;
    rd_data_d = '0;

    if (ctrl_wr) irq_en_d = cfg_wr_data[8];

    // Length may only change while the engine is not consuming it.
    if (len_wr && (state_q == S_IDLE || state_q == S_DONE)) len_d = cfg_wr_data;

    // Read-to-clear: the read below still samples ap_done before it drops.
    if (ctrl_rd && ap_done) done_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Abort is meaningless here; a start with zero length is dropped.
        if (start_req && (len_cnt != '0)) state_d = S_START;
      end
      S_START: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (abort_req) begin
          // Counters hold; the next START clears them.
          state_d = S_IDLE;
        end else begin
          if (in_beat) in_cnt_d = in_cnt_q + CNT_ONE;
          if (out_beat) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
            if (sm_tlast) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new start wins over a concurrent read-to-clear and drops old done.
    if (state_d == S_START) done_d = 1'b0;

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    start_d  = (state_d == S_START);
    idle_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    fir_en_d = (state_d == S_RUN);
    accept_d = (state_d == S_RUN) && (in_cnt_d < len_cnt);
    irq_d    = done_d && irq_en_d;

    if (cfg_rd_en) begin
      if (cfg_rd_addr == pCTRL_ADDR) begin
        rd_data_d[0] = ap_start;
        rd_data_d[1] = ap_done;
        rd_data_d[2] = ap_idle;
        rd_data_d[8] = irq_en_q;
      end else if (cfg_rd_addr == pLEN_ADDR) begin
        rd_data_d = len_q;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      len_q        <= '0;
      irq_en_q     <= 1'b0;
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b1;
      fir_en       <= 1'b0;
      ss_accept_en <= 1'b0;
      irq          <= 1'b0;
      cfg_rd_data  <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      len_q        <= len_d;
      irq_en_q     <= irq_en_d;
      ap_start     <= start_d;
      ap_done      <= done_d;
      ap_idle      <= idle_d;
      fir_en       <= fir_en_d;
      ss_accept_en <= accept_d;
      irq          <= irq_d;
      cfg_rd_data  <= rd_data_d;
    end
  end

endmodule
